// File: rtl/anti_theft_pkg.sv
// rtl/anti_theft_pkg.sv - shared constants and types for the anti-theft event logger
package anti_theft_pkg;

  localparam logic [3:0] SIREN_EVENT_CODE   = 4'hF;
  localparam int         LOG_DEPTH          = 8;
  localparam int         LOG_TS_W           = 8;
  localparam int         LOG_BROWSE_TIMEOUT = 10;

  // Entry layout at the default timestamp width.
  typedef struct packed {
    logic [3:0]          state;
    logic [LOG_TS_W-1:0] ts;
  } log_entry_t;

  typedef enum logic {
    LIVE   = 1'b0,
    BROWSE = 1'b1
  } log_mode_e;

endpackage

// File: rtl/event_logger_if.sv
// rtl/event_logger_if.sv - FSM-side inputs and display-side outputs of the event logger
interface event_logger_if #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) ();

  localparam int AW = $clog2(DEPTH);

  logic [3:0]      ea;
  logic            one_hz_enable;
  logic            enable_siren;
  logic            browse_next;
  logic            log_clear;

  logic [3:0]      entry_state;
  logic [TS_W-1:0] entry_time;
  logic [AW-1:0]   entry_index;
  logic            entry_valid;
  logic [AW:0]     log_count;
  logic [3:0]      alarm_count;
  logic            browsing;

  modport slave (
    input  ea, one_hz_enable, enable_siren, browse_next, log_clear,
    output entry_state, entry_time, entry_index, entry_valid,
           log_count, alarm_count, browsing
  );

  modport master (
    output ea, one_hz_enable, enable_siren, browse_next, log_clear,
    input  entry_state, entry_time, entry_index, entry_valid,
           log_count, alarm_count, browsing
  );

endinterface

// File: rtl/event_ring_buffer.sv
// rtl/event_ring_buffer.sv - circular entry store with saturating count and
// an age-addressed registered read port
module event_ring_buffer #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [3:0]      wr_state,
  input  logic [TS_W-1:0] wr_ts,
  input  logic [AW-1:0]   offset,
  output logic [CW-1:0]   count,
  output logic [3:0]      rd_state,
  output logic [TS_W-1:0] rd_ts,
  output logic [AW-1:0]   rd_index,
  output logic            rd_valid
);

  typedef struct packed {
    logic [3:0]      state;
    logic [TS_W-1:0] ts;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;

  // Age 0 is the slot just behind the write pointer; DEPTH is a power of two.
  assign rd_addr = wr_ptr - AW'(1) - offset;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{state: wr_state, ts: wr_ts};
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (count != CW'(DEPTH)) begin
        count <= count + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= '0;
      rd_ts    <= '0;
      rd_index <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_index <= offset;
      rd_valid <= (count != '0);
      if (count != '0) begin
        rd_state <= mem[rd_addr].state;
        rd_ts    <= mem[rd_addr].ts;
      end else begin
        rd_state <= '0;
        rd_ts    <= '0;
      end
    end
  end

endmodule

// File: rtl/event_logger.sv
// rtl/event_logger.sv - logs anti-theft FSM state changes with timestamps and a browsable view.
// Optional: LOG_SIREN_EVENTS_EN also logs siren activations as SIREN_EVENT_CODE entries.
module event_logger import anti_theft_pkg::*; #(
  parameter int DEPTH          = LOG_DEPTH,
  parameter int TS_W           = LOG_TS_W,
  parameter int BROWSE_TIMEOUT = LOG_BROWSE_TIMEOUT
) (
  input  logic          clock,
  input  logic          reset,
  event_logger_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(BROWSE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(BROWSE_TIMEOUT - 1);

  logic            prime;
  logic [3:0]      ea_q;
  logic [TS_W-1:0] ts;
  logic            browse_q;
  logic            clear_q;
  logic            siren_q;
  logic [3:0]      alarm_count;

  log_mode_e       mode, mode_next;
  logic [AW-1:0]   offset, offset_next;
  logic [IW-1:0]   idle_cnt, idle_next;
  logic [CW-1:0]   count;

  logic            browse_edge;
  logic            clear_edge;
  logic            siren_edge;
  logic            state_event;

  logic            wr_en;
  logic [3:0]      wr_state;
  logic [TS_W-1:0] wr_ts;

  logic [3:0]      rd_state;
  logic [TS_W-1:0] rd_ts;
  logic [AW-1:0]   rd_index;
  logic            rd_valid;

  assign browse_edge = bus.browse_next  & ~browse_q;
  assign clear_edge  = bus.log_clear    & ~clear_q;
  assign siren_edge  = bus.enable_siren & ~siren_q;
  assign state_event = prime & (bus.ea != ea_q);

`ifdef LOG_SIREN_EVENTS_EN
  logic            pend_valid;
  logic [TS_W-1:0] pend_ts;

  // A state change owns the write slot; a siren entry waits one cycle in pend_*.
  always_comb begin
    wr_en    = ~clear_edge & (state_event | pend_valid | siren_edge);
    wr_state = SIREN_EVENT_CODE;
    wr_ts    = ts;
    if (state_event) begin
      wr_state = bus.ea;
    end else if (pend_valid) begin
      wr_ts = pend_ts;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear_edge) begin
      pend_valid <= 1'b0;
      pend_ts    <= '0;
    end else if (state_event && pend_valid) begin
      pend_valid <= 1'b1;
    end else if (siren_edge && (state_event || pend_valid)) begin
      pend_valid <= 1'b1;
      pend_ts    <= ts;
    end else begin
      pend_valid <= 1'b0;
    end
  end
`else
  always_comb begin
    wr_en    = state_event & ~clear_edge;
    wr_state = bus.ea;
    wr_ts    = ts;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      prime       <= 1'b0;
      ea_q        <= '0;
      ts          <= '0;
      browse_q    <= 1'b0;
      clear_q     <= 1'b0;
      siren_q     <= 1'b0;
      alarm_count <= '0;
    end else begin
      prime    <= 1'b1;
      ea_q     <= bus.ea;
      browse_q <= bus.browse_next;
      clear_q  <= bus.log_clear;
      siren_q  <= bus.enable_siren;
      if (bus.one_hz_enable) begin
        ts <= ts + 1'b1;
      end
      if (clear_edge) begin
        alarm_count <= '0;
      end else if (siren_edge && alarm_count != 4'hF) begin
        alarm_count <= alarm_count + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode     <= LIVE;
      offset   <= '0;
      idle_cnt <= '0;
    end else begin
      mode     <= mode_next;
      offset   <= offset_next;
      idle_cnt <= idle_next;
    end
  end

  always_comb begin
    mode_next   = mode;
    offset_next = offset;
    idle_next   = idle_cnt;
    if (clear_edge || wr_en) begin
      mode_next   = LIVE;
      offset_next = '0;
      idle_next   = '0;
    end else begin
      case (mode)
        LIVE: begin
          offset_next = '0;
          idle_next   = '0;
          if (browse_edge && count != '0) begin
            mode_next   = BROWSE;
            offset_next = (count > CW'(1)) ? AW'(1) : '0;
          end
        end
        BROWSE: begin
          if (browse_edge) begin
            idle_next   = '0;
            offset_next = ({1'b0, offset} == count - CW'(1)) ? '0 : offset + AW'(1);
          end else if (bus.one_hz_enable) begin
            if (idle_cnt == IDLE_LAST) begin
              mode_next   = LIVE;
              offset_next = '0;
              idle_next   = '0;
            end else begin
              idle_next = idle_cnt + IW'(1);
            end
          end
        end
      endcase
    end
  end

  event_ring_buffer #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) u_ring (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear_edge),
    .wr_en    (wr_en),
    .wr_state (wr_state),
    .wr_ts    (wr_ts),
    .offset   (offset),
    .count    (count),
    .rd_state (rd_state),
    .rd_ts    (rd_ts),
    .rd_index (rd_index),
    .rd_valid (rd_valid)
  );

  assign bus.entry_state = rd_state;
  assign bus.entry_time  = rd_ts;
  assign bus.entry_index = rd_index;
  assign bus.entry_valid = rd_valid;
  assign bus.log_count   = count;
  assign bus.alarm_count = alarm_count;
  assign bus.browsing    = (mode == BROWSE);

endmodule

// File: tb/tb_event_logger.sv
// tb/tb_event_logger.sv - self-checking bench for event_logger against a queue-based log model
// Honours LOG_SIREN_EVENTS_EN the same way as the design.
module tb_event_logger;
  import anti_theft_pkg::*;

  localparam int DEPTH = 8;
  localparam int TS_W  = 8;
  localparam int TMO   = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;

  event_logger_if #(.DEPTH(DEPTH), .TS_W(TS_W)) bus ();

  event_logger #(
    .DEPTH          (DEPTH),
    .TS_W           (TS_W),
    .BROWSE_TIMEOUT (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Log model: newest entry at the queue front, age = queue index.
  log_entry_t m_q[$];
  bit         m_init = 0;
  bit         m_prime, m_br_q, m_clr_q, m_sir_q, m_browse, m_pend;
  logic [3:0] m_ea_q;
  logic [7:0] m_ts, m_pend_ts;
  int         m_alarm, m_off, m_idle;
  int         exp_state, exp_time, exp_index, exp_valid, exp_count, exp_alarm, exp_browsing;

  task automatic m_push(input logic [3:0] s, input logic [7:0] t);
    log_entry_t e;
    e.state = s;
    e.ts    = t;
    m_q.push_front(e);
    if (m_q.size() > DEPTH) m_q.delete(DEPTH);
  endtask

  always @(posedge clock) begin : model
    bit ce, be, se, ev, wrote;
    if (reset) begin
      m_q.delete();
      m_init = 1; m_prime = 0; m_ea_q = 0; m_ts = 0;
      m_br_q = 0; m_clr_q = 0; m_sir_q = 0;
      m_alarm = 0; m_browse = 0; m_off = 0; m_idle = 0; m_pend = 0; m_pend_ts = 0;
      exp_state = 0; exp_time = 0; exp_index = 0; exp_valid = 0;
      exp_count = 0; exp_alarm = 0; exp_browsing = 0;
    end else begin
      // Displayed entry reflects the log as it stood before this edge.
      exp_valid = (m_q.size() > 0);
      exp_index = m_off;
      exp_state = exp_valid ? int'(m_q[m_off].state) : 0;
      exp_time  = exp_valid ? int'(m_q[m_off].ts) : 0;

      ce = bus.log_clear    && !m_clr_q;
      be = bus.browse_next  && !m_br_q;
      se = bus.enable_siren && !m_sir_q;
      ev = m_prime && (bus.ea != m_ea_q);
      wrote = 0;
      if (ce) begin
        m_q.delete();
        m_alarm = 0; m_browse = 0; m_off = 0; m_idle = 0; m_pend = 0;
      end else begin
        if (se && m_alarm < 15) m_alarm++;
`ifdef LOG_SIREN_EVENTS_EN
        if (ev) begin
          m_push(bus.ea, m_ts); wrote = 1;
          if (se && !m_pend) begin m_pend = 1; m_pend_ts = m_ts; end
        end else if (m_pend) begin
          m_push(4'hF, m_pend_ts); wrote = 1;
          m_pend = se; m_pend_ts = m_ts;
        end else if (se) begin
          m_push(4'hF, m_ts); wrote = 1;
        end
`else
        if (ev) begin m_push(bus.ea, m_ts); wrote = 1; end
`endif
        if (wrote) begin
          m_browse = 0; m_off = 0; m_idle = 0;
        end else if (!m_browse) begin
          if (be && m_q.size() > 0) begin
            m_browse = 1; m_off = (m_q.size() > 1) ? 1 : 0; m_idle = 0;
          end
        end else if (be) begin
          m_off  = (m_off == m_q.size() - 1) ? 0 : m_off + 1;
          m_idle = 0;
        end else if (bus.one_hz_enable) begin
          m_idle++;
          if (m_idle == TMO) begin m_browse = 0; m_off = 0; m_idle = 0; end
        end
      end
      if (bus.one_hz_enable) m_ts = m_ts + 8'd1;
      m_ea_q = bus.ea; m_prime = 1;
      m_br_q = bus.browse_next; m_clr_q = bus.log_clear; m_sir_q = bus.enable_siren;
      exp_count = m_q.size(); exp_alarm = m_alarm; exp_browsing = m_browse;
    end
  end

  always @(negedge clock) begin
    if (m_init) begin
      check("cyc_entry_state", int'(bus.entry_state), exp_state);
      check("cyc_entry_time",  int'(bus.entry_time),  exp_time);
      check("cyc_entry_index", int'(bus.entry_index), exp_index);
      check("cyc_entry_valid", int'(bus.entry_valid), exp_valid);
      check("cyc_log_count",   int'(bus.log_count),   exp_count);
      check("cyc_alarm_count", int'(bus.alarm_count), exp_alarm);
      check("cyc_browsing",    int'(bus.browsing),    exp_browsing);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock); bus.one_hz_enable = 1'b1;
      @(negedge clock); bus.one_hz_enable = 1'b0;
    end
  endtask

  task automatic press();
    @(negedge clock); bus.browse_next = 1'b1;
    @(negedge clock); bus.browse_next = 1'b0;
  endtask

  task automatic set_ea(input logic [3:0] v);
    @(negedge clock); bus.ea = v;
  endtask

  task automatic entry_is(input string name, input int s, input int t, input int idx);
    check({name, "_state"}, int'(bus.entry_state), s);
    check({name, "_time"},  int'(bus.entry_time),  t);
    check({name, "_index"}, int'(bus.entry_index), idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ea = 4'd0; bus.one_hz_enable = 1'b0; bus.enable_siren = 1'b0;
    bus.browse_next = 1'b0; bus.log_clear = 1'b0;
    cyc(3); reset = 1'b0;
    cyc(1);
    check("rst_log_count", int'(bus.log_count), 0);
    check("rst_alarm", int'(bus.alarm_count), 0);
    check("rst_browsing", int'(bus.browsing), 0);
    entry_is("rst", 0, 0, 0);

    tick(3); cyc(2);
    check("prime_log_count", int'(bus.log_count), 0);
    check("prime_valid", int'(bus.entry_valid), 0);

    tick(2); set_ea(4'd1);
    tick(4); set_ea(4'd2);
    cyc(2);
    check("two_log_count", int'(bus.log_count), 2);
    check("two_valid", int'(bus.entry_valid), 1);
    entry_is("live_newest", 2, 9, 0);
    press(); cyc(2);
    check("browse1_mode", int'(bus.browsing), 1);
    entry_is("browse1", 1, 5, 1);
    press(); cyc(2);
    check("browse2_mode", int'(bus.browsing), 1);
    entry_is("browse2_wrap", 2, 9, 0);

    tick(TMO - 1); cyc(1);
    check("timeout_before", int'(bus.browsing), 1);
    tick(1); cyc(2);
    check("timeout_after", int'(bus.browsing), 0);
    check("timeout_index", int'(bus.entry_index), 0);

    for (int i = 0; i < 10; i++) begin
      tick(1); set_ea(4'(3 + i));
    end
    cyc(2);
    check("full_log_count", int'(bus.log_count), DEPTH);
    check("model_full_size", m_q.size(), DEPTH);
    entry_is("full_newest", 12, 29, 0);
    repeat (7) press();
    cyc(2);
    entry_is("full_oldest", 5, 22, 7);
    press(); cyc(2);
    entry_is("full_wrap", 12, 29, 0);
    press(); cyc(1);
    check("mid_browse_on", int'(bus.browsing), 1);
    set_ea(4'd13); cyc(2);
    check("mid_browse_forced_live", int'(bus.browsing), 0);
    entry_is("mid_browse_entry", 13, 29, 0);

    repeat (17) begin
      @(negedge clock); bus.enable_siren = 1'b1;
      @(negedge clock); bus.enable_siren = 1'b0;
    end
    cyc(2);
    check("alarm_saturate", int'(bus.alarm_count), 15);

    @(negedge clock); bus.log_clear = 1'b1; bus.ea = 4'd14;
    @(negedge clock); bus.log_clear = 1'b0;
    cyc(3);
    check("clear_log_count", int'(bus.log_count), 0);
    check("clear_alarm", int'(bus.alarm_count), 0);
    check("clear_valid", int'(bus.entry_valid), 0);
    entry_is("clear_entry", 0, 0, 0);

    @(negedge clock); bus.ea = 4'd3; bus.enable_siren = 1'b1;
    cyc(3);
    check("combo_alarm", int'(bus.alarm_count), 1);
`ifdef LOG_SIREN_EVENTS_EN
    check("combo_log_count", int'(bus.log_count), 2);
    entry_is("combo_siren", 15, 29, 0);
    press(); cyc(2);
    entry_is("combo_state", 3, 29, 1);
`else
    check("combo_log_count", int'(bus.log_count), 1);
    entry_is("combo_state", 3, 29, 0);
    press(); cyc(2);
    check("single_browse", int'(bus.browsing), 1);
    entry_is("single_entry", 3, 29, 0);
`endif
    bus.enable_siren = 1'b0;

    tick(256); set_ea(4'd4); cyc(2);
    entry_is("ts_wrap", 4, 29, 0);

    press(); cyc(2);
    check("pre_reset_browse", int'(bus.browsing), 1);
    @(negedge clock); reset = 1'b1; bus.ea = 4'd6;
    cyc(2); reset = 1'b0;
    cyc(1);
    check("reset_browse", int'(bus.browsing), 0);
    check("reset_log_count", int'(bus.log_count), 0);
    check("reset_valid", int'(bus.entry_valid), 0);
    cyc(3);
    check("reprime_log_count", int'(bus.log_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
